// File: rtl/mul_seq_ctrl.sv
// Sequential shift-and-add unsigned multiplier: one partial product per clock through a single
// WIDTH-bit adder. Optional macro MUL_SEQ_ZERO_BYPASS_EN completes zero-operand requests directly.
module mul_seq_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic                 iStart,
  input  logic [WIDTH-1:0]     iA,
  input  logic [WIDTH-1:0]     iB,
  output logic [2*WIDTH-1:0]   oResult,
  output logic                 oBusy,
  output logic                 oDone
);

  localparam int unsigned AccW = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [AccW-1:0]  acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [AccW-1:0]  result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [AccW-1:0]  acc_step;
  logic             last_iter;
  logic             zero_bypass;

  // Upper half of the accumulator plus the selected multiplicand, carry kept.
  always_comb begin
    addend    = mplier_q[0] ? mcand_q : '0;
    sum       = {1'b0, acc_q[AccW-1:WIDTH]} + {1'b0, addend};
    // Carry lands in the MSB as the whole accumulator shifts right by one.
    acc_step  = AccW'({sum, acc_q[WIDTH-1:0]} >> 1);
    last_iter = (cnt_q == CntW'(WIDTH - 1));
  end

`ifdef MUL_SEQ_ZERO_BYPASS_EN
  assign zero_bypass = (iA == '0) || (iB == '0);
`else
  assign zero_bypass = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      StIdle: begin
        if (iStart) begin
          mcand_d  = iA;
          mplier_d = iB;
          acc_d    = '0;
          cnt_d    = '0;
          if (zero_bypass) begin
            result_d = '0;
            state_d  = StDone;
          end else begin
            state_d  = StCalc;
          end
        end
      end
      StCalc: begin
        acc_d    = acc_step;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (last_iter) begin
          result_d = acc_step;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign oResult = result_q;
  assign oBusy   = busy_q;
  assign oDone   = done_q;

`ifndef SYNTHESIS
  always_ff @(posedge Clock) begin
    if (Reset_n) begin
      assert (busy_q == (state_q != StIdle))
        else $error("busy flag out of step with state");
      assert (done_q == (state_q == StDone))
        else $error("done flag out of step with state");
    end
  end
`endif

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Randomized self-checking bench for mul_seq_ctrl against an arithmetic product/latency model.
module tb_mul_seq_ctrl;

  localparam int unsigned W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [2*W-1:0] result;
  logic           busy;
  logic           done;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl #(.WIDTH(W)) dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .iStart  (start),
    .iA      (a),
    .iB      (b),
    .oResult (result),
    .oBusy   (busy),
    .oDone   (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Edges after the accepting edge until done is visible.
  function automatic int exp_latency(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef MUL_SEQ_ZERO_BYPASS_EN
    if (x == 0 || y == 0) return 0;
`endif
    return W;
  endfunction

  function automatic logic [31:0] product(input logic [W-1:0] x, input logic [W-1:0] y);
    return 32'(x) * 32'(y);
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) check_eq("idle_timeout", 32'(busy), 0);
  endtask

  task automatic count_done(input int cycles, input string tag);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check_eq(tag, seen, 0);
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
    logic [2*W-1:0] prev;
    int k;
    bit held;
    wait_idle();
    prev  = result;
    held  = 1'b1;
    start = 1'b1;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    check_eq({tag, "_busy"}, 32'(busy), 1);
    k = 0;
    while (!done && k < 40) begin
      if (result !== prev) held = 1'b0;
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_lat"}, k, exp_latency(x, y));
    check_eq({tag, "_res"}, 32'(result), product(x, y));
    check_eq({tag, "_hold"}, 32'(held), 1);
    @(negedge clk);
    check_eq({tag, "_pulse"}, {30'd0, done, busy}, 0);
    check_eq({tag, "_keep"}, 32'(result), product(x, y));
  endtask

  initial begin
    int t;
    int ndone;
    int times [2];
    logic [31:0] res [2];
    logic [W-1:0] x, y;

    repeat (2) @(negedge clk);
    check_eq("rst_result", 32'(result), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    count_done(20, "idle_no_done");

    run_op(4'd3, 4'd5, "m3x5");
    repeat (3) @(negedge clk);
    check_eq("m3x5_idle_hold", 32'(result), 15);
    run_op(4'd15, 4'd15, "m15x15");

    // Start held high: second operands presented right after the first acceptance.
    wait_idle();
    start = 1'b1;
    a = 4'd2;
    b = 4'd7;
    @(negedge clk);
    a = 4'd9;
    b = 4'd9;
    t = 0;
    ndone = 0;
    while (t < 40) begin
      if (done) begin
        times[ndone] = t;
        res[ndone]   = 32'(result);
        ndone++;
        if (ndone == 2) begin
          start = 1'b0;
          break;
        end
      end
      @(negedge clk);
      t++;
    end
    check_eq("b2b_count", ndone, 2);
    if (ndone == 2) begin
      check_eq("b2b_first_lat", times[0], W);
      check_eq("b2b_res0", res[0], 14);
      check_eq("b2b_res1", res[1], 81);
      check_eq("b2b_gap", times[1] - times[0], W + 2);
    end
    @(negedge clk);
    check_eq("b2b_stop", 32'(busy), 0);

    // Reset in the middle of a calculation discards it.
    wait_idle();
    start = 1'b1;
    a = 4'd7;
    b = 4'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_outs", {result, 6'd0, done, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_done(20, "midrst_no_done");
    run_op(4'd4, 4'd4, "m4x4");

    run_op(4'd0, 4'd11, "zero_a");
    run_op(4'd3, 4'd5, "m3x5_again");

    for (int i = 0; i < 40; i++) begin
      x = W'($urandom_range(0, 15));
      y = W'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) x = '0;
      if ($urandom_range(0, 5) == 0) y = '0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(x, y, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Iterative shift-and-add multiplier controller built around a single WIDTH-bit adder cell chain.
- Replaces the fully unrolled array of 1-bit adder cells: one partial product per clock, sequenced by a small FSM.
- Start/busy/done handshake to the surrounding lab datapath.
- Used where area matters more than latency. One product per WIDTH+2 cycles.

Parameters:
- WIDTH, 4, operand width in bits (legal values 2..16); the product is 2*WIDTH bits.

Ports:
- Clock  input  1  single rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset.
- iStart  input  1  request a multiplication; sampled only in IDLE.
- iA  input  WIDTH  multiplicand; captured on the accepted iStart edge.
- iB  input  WIDTH  multiplier; captured on the accepted iStart edge.
- oResult  output  2*WIDTH  registered product; held until the next product completes.
- oBusy  output  1  high whenever the FSM is not in IDLE.
- oDone  output  1  one-cycle pulse marking a new valid oResult.

Behaviour:
- Interface: one clock (Clock); reset is asynchronous and active-low (Reset_n).
- Reset (Reset_n low, any time, including mid-operation):
  - state=IDLE.
  - oResult=0, oBusy=0, oDone=0.
  - Multiplicand, multiplier, accumulator and counter all cleared.
  - The in-flight operation is discarded, with no done pulse afterwards.
- States: IDLE, CALC, DONE. oBusy is registered and equals (state!=IDLE).
- IDLE:
  - When iStart=1 at an edge: mcand<=iA, mplier<=iB, acc<=0, cnt<=0, go to CALC.
  - When iStart=0: stay in IDLE.
- CALC (one iteration per edge):
  - sum[WIDTH:0] = acc[2W-1:W] + (mplier[0] ? mcand : 0), computed with a full carry out.
  - {acc, mplier} <= {sum, acc[W-1:0], mplier[W-1:1]} shifted right by one, so the carry enters the MSB.
  - cnt<=cnt+1.
  - At the edge where cnt==WIDTH-1: oResult<=final acc value, go to DONE.
- DONE:
  - oDone=1 for exactly this one cycle.
  - Next edge returns to IDLE, with oDone=0.
- Latency, with the start accepted at edge 0:
  - Iterations occur on edges 1..WIDTH.
  - oResult is valid and oDone is high in the cycle after edge WIDTH.
  - oBusy is high from edge 0 until edge WIDTH+1.
- iStart in CALC or DONE is ignored, not queued. iA and iB may change freely after acceptance.
- iStart held high continuously gives a back-to-back restart. The next start is accepted at the edge leaving IDLE, so the period is WIDTH+2 cycles.
- Arithmetic is unsigned. Max product (2^W-1)^2 fits in 2*WIDTH bits with no overflow. The counter is $clog2(WIDTH)+1 bits.
- oResult changes only on the edge entering DONE, or on reset.

Optional Feature:
- Macro: MUL_SEQ_ZERO_BYPASS_EN.
- Defined:
  - In IDLE, if iStart=1 and (iA==0 or iB==0), the FSM goes directly to DONE and skips CALC.
  - oResult<=0 on that edge.
  - oDone is high in the next cycle, giving a latency of 1 cycle instead of WIDTH+1.
  - Non-zero operands behave exactly as without the macro.
- Undefined: zero operands take the full WIDTH iterations and yield 0.

Test Plan (WIDTH=4):
- Reset_n low then high, with iStart=0 -> oResult=0, oBusy=0, oDone=0, and oDone stays low for 20 cycles.
- iA=3, iB=5, iStart pulse at edge 0 -> oBusy=1 from edge 0; oDone=1 only in the cycle after edge 4; oResult=15, held until the next completion.
- iA=15, iB=15 -> oResult=225 (0xE1). Change iA/iB during CALC -> result unaffected.
- iStart held high continuously, with iA=2, iB=7 and then iA=9, iB=9 after the first acceptance -> products 14 then 81; done pulses 6 cycles apart; no iStart accepted during CALC or DONE.
- Start iA=7, iB=6, then Reset_n low for 1 cycle after edge 2 -> all outputs 0 immediately; no oDone; next start with iA=4, iB=4 -> 16 at normal latency.
- iA=0, iB=11:
  - Macro undefined -> oDone after edge 4, oResult=0.
  - MUL_SEQ_ZERO_BYPASS_EN defined -> oDone in the cycle after edge 0, oResult=0.
  - Non-zero case with the macro defined still returns 15 for 3*5 after edge 4.
